clock_divider_bank: RTL

//   Multi-channel programmable clock divider and tick generator that replaces fixed single-ratio dividers.

---
 rtl/clkdiv_pkg.sv | 13 +
 rtl/clock_divider_channel.sv | 85 ++++++++
 rtl/clock_divider_bank.sv | 38 +++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and the overflow-safe half-period helper for the divider bank.
package clkdiv_pkg;

    localparam int DEF_CNT_W = 32;
    localparam int MIN_DIV   = 2;
    localparam int MAX_W     = 64;

    // ceil(n/2) as (n>>1)+n[0] so an all-ones ratio cannot carry out
    function automatic logic [MAX_W-1:0] half_ratio(input logic [MAX_W-1:0] n);
        return (n >> 1) + MAX_W'(n[0]);
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// clock_divider_channel: one programmable divider channel with a staged ratio that is
// swapped in only at period boundaries, producing a divided clock and a period-start tick.
module clock_divider_channel
    import clkdiv_pkg::*;
#(
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = 100_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [CNT_W-1:0] ratio_i,
    input  logic             load_i,
    input  logic             sync_i,
    output logic             pending_o,
    output logic             clk_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] n_q, n_d, stg_q, stg_d, cnt_q, cnt_d;
    logic [CNT_W-1:0] ld_val, n_next, cnt_inc, half;
    logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, wrap;

    assign ld_val  = ratio_i < CNT_W'(MIN_DIV) ? CNT_W'(MIN_DIV) : ratio_i;
    // ratio for the period that starts at a boundary: a fresh load beats a staged one
    assign n_next  = load_i ? ld_val : pend_q ? stg_q : n_q;
    assign wrap    = sync_i || cnt_q == n_q - ONE;
    assign cnt_inc = cnt_q + ONE;
    assign half    = CNT_W'(half_ratio(MAX_W'(n_q)));

    always_comb begin
        n_d    = n_q;
        stg_d  = stg_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        clk_d  = 1'b0;
        tick_d = 1'b0;
        if (!en_i) begin
            n_d    = n_next;
            stg_d  = n_next;
            cnt_d  = n_next - ONE;
            pend_d = 1'b0;
        end else if (wrap) begin
            n_d    = n_next;
            stg_d  = n_next;
            cnt_d  = '0;
            pend_d = 1'b0;
            tick_d = 1'b1;
            clk_d  = 1'b1;
        end else begin
            cnt_d = cnt_inc;
            clk_d = cnt_inc < half;
            if (load_i) begin
                stg_d  = ld_val;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q    <= DEF_N;
            stg_q  <= DEF_N;
            cnt_q  <= DEF_N - ONE;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            n_q    <= n_d;
            stg_q  <= stg_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign pending_o = pend_q;
    assign clk_o     = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: a bank of independent programmable clock dividers with a shared
// phase-alignment sync strobe.
module clock_divider_bank
    import clkdiv_pkg::*;
#(
    parameter int          CHANNELS    = 4,
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = 100_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*CNT_W-1:0] div_ratio,
    input  logic [CHANNELS-1:0]       load,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       pending,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        clock_divider_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (en[g]),
            .ratio_i   (div_ratio[g*CNT_W +: CNT_W]),
            .load_i    (load[g]),
            .sync_i    (sync),
            .pending_o (pending[g]),
            .clk_o     (clk_out[g]),
            .tick_o    (tick[g])
        );
    end

endmodule
